prbs16_checker: RTL

Serial PRBS receiver/checker for the 16-bit Fibonacci pattern x^16+x^14+x^13+x^11+1 (taps at register bits 15, 13, 12 and 10; new bit shifted into bit 0). It sits at the receive end of a PRBS link-test path, fed one bit per qualified cycle. It self-synchronises to the incoming stream, declares lock, then free-runs its own LFSR as a flywheel. It reports per-bit errors, a saturating error count, and loss of lock.

---
 rtl/prbs16_pkg.sv | 27 ++
 rtl/prbs16_err_window.sv | 62 ++++++
 rtl/prbs16_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/prbs16_pkg.sv
// prbs16_pkg: shared definitions for the PRBS16 checker family.
//   TAP_MASK       - feedback taps of x^16+x^14+x^13+x^11+1 (bits 15, 13, 12, 10)
//   state_e        - checker state {HUNT, LOCKED}
//   *_W            - counter widths sized for the legal parameter ranges
//   prbs16_predict - next expected bit from the 16-bit history register
package prbs16_pkg;

  localparam logic [15:0] TAP_MASK = 16'hB400;

  localparam int unsigned FILL_W    = 5;   // fill counter, saturates at 16
  localparam int unsigned RUN_W     = 8;   // good-run counter, LOCK_COUNT <= 255
  localparam int unsigned WIN_W     = 10;  // window counters, ERR_WINDOW <= 1023
  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned BIT_CNT_W = 32;

  localparam logic [FILL_W-1:0] FILL_FULL = 5'd16;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  function automatic logic prbs16_predict(input logic [15:0] r);
    return ^(r & TAP_MASK);
  endfunction

endpackage

// File: rtl/prbs16_err_window.sv
// prbs16_err_window: windowed error counter used for loss-of-lock detection.
// Counts advance bits 0..ERR_WINDOW-1, then clears both bit and error counts.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   clear        - synchronous clear of both counters (held while not checking)
//   advance      - one checked bit this cycle
//   err          - the checked bit was in error
//   thresh_hit   - combinational: this bit is the ERR_THRESH-th error of the window
module prbs16_err_window
  import prbs16_pkg::*;
#(
  parameter int unsigned ERR_WINDOW = 64,
  parameter int unsigned ERR_THRESH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic advance,
  input  logic err,
  output logic thresh_hit
);

  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(ERR_WINDOW - 1);
  localparam logic [WIN_W-1:0] THRESH_M1 = WIN_W'(ERR_THRESH - 1);

  logic [WIN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIN_W-1:0] err_cnt_q, err_cnt_d;

  // Hit is judged on the count before this bit, so the threshold fires on the
  // same edge that samples the offending bit.
  always_comb begin
    thresh_hit = advance & err & (err_cnt_q == THRESH_M1);
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else if (advance) begin
      if (bit_cnt_q == WIN_LAST) begin
        bit_cnt_d = '0;
        err_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        err_cnt_d = err_cnt_q + WIN_W'(err);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: rtl/prbs16_checker.sv
// prbs16_checker: serial PRBS16 (x^16+x^14+x^13+x^11+1) receive checker.
// Self-synchronises in HUNT, then flywheels its own LFSR in LOCKED.
// Optional build macro: PRBS16_CHK_BITCNT_EN builds the checked-bit counter;
// otherwise bit_count is tied to zero (port list unchanged).
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   din_valid    - qualifies din; nothing advances without it
//   din          - received PRBS bit
//   clear_cnt    - synchronous clear of err_count and bit_count
//   locked       - high while in LOCKED
//   bit_err      - one-cycle pulse on a mismatch while LOCKED
//   lock_lost    - one-cycle pulse on LOCKED -> HUNT
//   err_count    - saturating error count (LOCKED only)
//   bit_count    - bits checked in LOCKED (optional, wraps)
module prbs16_checker
  import prbs16_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 32,
  parameter int unsigned ERR_WINDOW = 64,
  parameter int unsigned ERR_THRESH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din_valid,
  input  logic        din,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        bit_err,
  output logic        lock_lost,
  output logic [15:0] err_count,
  output logic [31:0] bit_count
);

  localparam logic [RUN_W-1:0] LOCK_M1 = RUN_W'(LOCK_COUNT - 1);

  state_e                 state_q, state_d;
  logic [15:0]            r_q, r_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   bit_err_q, bit_err_d;
  logic                   lock_lost_q, lock_lost_d;

  logic pred;
  logic mismatch;
  logic checking;
  logic win_hit;

  assign pred     = prbs16_predict(r_q);
  assign mismatch = din ^ pred;
  assign checking = din_valid & (state_q == LOCKED);

  // Window counters are held clear throughout HUNT, so each lock starts fresh.
  prbs16_err_window #(
    .ERR_WINDOW (ERR_WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_err_window (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (state_q == HUNT),
    .advance    (checking),
    .err        (mismatch),
    .thresh_hit (win_hit)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_d      = fill_q;
    run_d       = run_q;
    err_cnt_d   = err_cnt_q;
    bit_err_d   = 1'b0;
    lock_lost_d = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          r_d = {r_q[14:0], din};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
          end else if (!mismatch && (r_q != 16'h0000)) begin
            // All-zero history is a degenerate LFSR state and never locks.
            if (run_q == LOCK_M1) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          r_d = {r_q[14:0], pred};
          if (mismatch) begin
            bit_err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
          if (win_hit) begin
            state_d     = HUNT;
            lock_lost_d = 1'b1;
            fill_d      = '0;
            run_d       = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clear_cnt) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      r_q         <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      err_cnt_q   <= '0;
      bit_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      err_cnt_q   <= err_cnt_d;
      bit_err_q   <= bit_err_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign bit_err   = bit_err_q;
  assign lock_lost = lock_lost_q;
  assign err_count = err_cnt_q;

`ifdef PRBS16_CHK_BITCNT_EN
  logic [BIT_CNT_W-1:0] bit_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
    end else if (clear_cnt) begin
      bit_cnt_q <= '0;
    end else if (checking) begin
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  assign bit_count = bit_cnt_q;
`else
  assign bit_count = '0;
`endif

endmodule
